// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Control FSM for a multi-cycle MIPS datapath with one shared ALU and one
// shared memory. Each instruction is walked through fetch, decode, execute,
// memory and writeback. The FSM also flags illegal instructions and counts
// the instructions it retires.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   opcode, funct     instruction fields from the parser (valid from DECODE)
//   zero              ALU zero flag (the datapath combines it with pc_write_cond)
//   mem_ready         memory finishes the current access this cycle
//   pc_write .. imm_zext, reg_dst, mem_to_reg, alu_src_b, alu_ctrl,
//   pc_source         datapath mux selects and write enables
//   illegal           high while sitting in TRAP
//   state             current FSM state, for debug
//   instr_count       retired-instruction counter, wraps at 2^COUNT_W
module mips_multicycle_ctrl #(
    parameter int COUNT_W     = 32,
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               imm_zext,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         alu_src_b,
    output logic [3:0]         alu_ctrl,
    output logic [1:0]         pc_source,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_R_EXEC    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_I_EXEC    = 4'd11;
    localparam logic [3:0] S_I_WB      = 4'd12;
    localparam logic [3:0] S_JAL       = 4'd13;
    localparam logic [3:0] S_JR        = 4'd14;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       retire;

    assign state   = state_q;
    assign illegal = (state_q == S_TRAP);

    // An instruction retires on the last cycle it spends in its final state.
    // Every one of these states goes back to FETCH on the next edge. A store
    // only finishes when memory accepts it.
    assign retire = (state_q == S_MEM_WB) || (state_q == S_R_WB) ||
                    (state_q == S_BRANCH) || (state_q == S_I_WB) ||
                    (state_q == S_JUMP)   || (state_q == S_JAL)  ||
                    (state_q == S_JR)     ||
                    ((state_q == S_MEM_WRITE) && mem_ready);

    // State register and retire counter. Reset takes priority over
    // everything. An instruction cut off mid-flight therefore never
    // reaches a write state and is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

    // Next-state logic. DECODE does the dispatch. MEM_ADDR chooses between
    // the load path and the store path. The three memory-facing states
    // stall until mem_ready is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        case (funct)
                            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: state_d = S_R_EXEC;
                            6'h08:                             state_d = S_JR;
                            default:                           state_d = S_TRAP;
                        endcase
                    end
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_ADDI, OP_ORI: state_d = S_I_EXEC;
                    OP_J:            state_d = S_JUMP;
                    OP_JAL:          state_d = S_JAL;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_JR:        state_d = S_FETCH;
            S_TRAP:      state_d = TRAP_STICKY ? S_TRAP : S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode. Every control starts at 0 and each state raises only
    // what it needs. FETCH is the only Mealy state. It loads IR and PC in
    // the same cycle that memory returns the word, so a stalled fetch
    // leaves IR and PC unchanged. BRANCH raises pc_write_cond; the datapath
    // ANDs it with the zero flag.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        imm_zext      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_b     = 2'b00;
        alu_ctrl      = 4'b0000;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'h22:   alu_ctrl = ALU_SUB;
                    6'h24:   alu_ctrl = ALU_AND;
                    6'h25:   alu_ctrl = ALU_OR;
                    6'h2A:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_ORI) begin
                    alu_ctrl = ALU_OR;
                    imm_zext = 1'b1;
                end else begin
                    alu_ctrl = ALU_ADD;
                end
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Bench for mips_multicycle_ctrl. Each instruction is expanded into the
// list of states it should visit and the mem_ready value driven in each.
// Every cycle is then compared against the control values the instruction
// set expects for that step. A narrow counter is used so the retire count
// wraps during the random run.
module tb_mips_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2;
    localparam logic [3:0] ST_MADDR = 4'd3, ST_MREAD = 4'd4,  ST_MWB = 4'd5;
    localparam logic [3:0] ST_MWRITE = 4'd6, ST_REXEC = 4'd7, ST_RWB = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_IEXEC = 4'd11;
    localparam logic [3:0] ST_IWB = 4'd12,  ST_JAL = 4'd13,   ST_JR = 4'd14;
    localparam logic [3:0] ST_TRAP = 4'd15;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_J = 4;
    localparam int C_JAL = 5, C_JR = 6, C_ADDI = 7, C_ORI = 8, C_ILL = 9;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       imm_zext;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
    } phase_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic reg_write, alu_src_a, imm_zext, illegal;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [3:0] alu_ctrl, state;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] model_count = '0;
    ctrl_t obs;

    mips_multicycle_ctrl #(.COUNT_W(CW), .TRAP_STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .imm_zext(imm_zext),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .pc_source(pc_source), .illegal(illegal),
        .state(state), .instr_count(instr_count)
    );

    assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  reg_write, alu_src_a, imm_zext, reg_dst, mem_to_reg, alu_src_b,
                  alu_ctrl, pc_source, illegal};

    always #5 clk = ~clk;

    // Sort an instruction into its instruction-set class
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h04: return C_BEQ;
            6'h02: return C_J;
            6'h03: return C_JAL;
            6'h08: return C_ADDI;
            6'h0D: return C_ORI;
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                    return C_R;
                if (fn == 6'h08)
                    return C_JR;
                return C_ILL;
            end
            default: return C_ILL;
        endcase
    endfunction

    // Required control values for one step of an instruction
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                       input logic [5:0] fn, input logic rdy);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_ctrl = 4'b0010;
                             c.ir_write = rdy; c.pc_write = rdy; end
            ST_DECODE: begin c.alu_src_b = 2'b11; c.alu_ctrl = 4'b0010; end
            ST_MADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 4'b0010; end
            ST_MREAD:  begin c.mem_read = 1; c.iord = 1; end
            ST_MWB:    begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
            ST_MWRITE: begin c.mem_write = 1; c.iord = 1; end
            ST_REXEC: begin
                c.alu_src_a = 1;
                case (fn)
                    6'h20: c.alu_ctrl = 4'b0010;
                    6'h22: c.alu_ctrl = 4'b0110;
                    6'h24: c.alu_ctrl = 4'b0000;
                    6'h25: c.alu_ctrl = 4'b0001;
                    default: c.alu_ctrl = 4'b0111;
                endcase
            end
            ST_RWB:    begin c.reg_write = 1; c.reg_dst = 2'b01; end
            ST_BRANCH: begin c.alu_src_a = 1; c.alu_ctrl = 4'b0110; c.pc_write_cond = 1;
                             c.pc_source = 2'b01; end
            ST_IEXEC: begin
                c.alu_src_a = 1; c.alu_src_b = 2'b10;
                c.alu_ctrl = (op == 6'h0D) ? 4'b0001 : 4'b0010;
                c.imm_zext = (op == 6'h0D);
            end
            ST_IWB:    c.reg_write = 1;
            ST_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
            ST_JAL:    begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1;
                             c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
            ST_JR:     begin c.pc_write = 1; c.pc_source = 2'b11; end
            ST_TRAP:   c.illegal = 1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    // Hold reset for n cycles. In each of them the DUT must show IDLE,
    // all controls low and a zero counter.
    task automatic apply_reset(input int n);
        rst = 1'b1;
        model_count = '0;
        repeat (n) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            #1;
            checks += 3;
            if (state !== ST_IDLE) begin
                errors++;
                $display("[TB] FAIL reset_state got=%0d exp=%0d", state, ST_IDLE);
            end
            if (obs !== ctrl_t'(0)) begin
                errors++;
                $display("[TB] FAIL reset_ctrl got=%h exp=%h", obs, ctrl_t'(0));
            end
            if (instr_count !== model_count) begin
                errors++;
                $display("[TB] FAIL reset_count got=%0d exp=%0d", instr_count, model_count);
            end
        end
        rst = 1'b0;
    endtask

    // Run one instruction, starting with the DUT in FETCH. abort_at >= 0
    // asserts reset after that step has been checked.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fetch_waits, input int mem_waits, input int abort_at);
        phase_t q[$];
        int cls;
        opcode = op;
        funct  = fn;
        cls = classify(op, fn);
        for (int i = 0; i < fetch_waits; i++) q.push_back('{ST_FETCH, 1'b0});
        q.push_back('{ST_FETCH, 1'b1});
        q.push_back('{ST_DECODE, 1'($urandom)});
        case (cls)
            C_LW: begin
                q.push_back('{ST_MADDR, 1'($urandom)});
                for (int i = 0; i < mem_waits; i++) q.push_back('{ST_MREAD, 1'b0});
                q.push_back('{ST_MREAD, 1'b1});
                q.push_back('{ST_MWB, 1'($urandom)});
            end
            C_SW: begin
                q.push_back('{ST_MADDR, 1'($urandom)});
                for (int i = 0; i < mem_waits; i++) q.push_back('{ST_MWRITE, 1'b0});
                q.push_back('{ST_MWRITE, 1'b1});
            end
            C_R: begin
                q.push_back('{ST_REXEC, 1'($urandom)});
                q.push_back('{ST_RWB, 1'($urandom)});
            end
            C_ADDI, C_ORI: begin
                q.push_back('{ST_IEXEC, 1'($urandom)});
                q.push_back('{ST_IWB, 1'($urandom)});
            end
            C_BEQ: q.push_back('{ST_BRANCH, 1'($urandom)});
            C_J:   q.push_back('{ST_JUMP, 1'($urandom)});
            C_JAL: q.push_back('{ST_JAL, 1'($urandom)});
            C_JR:  q.push_back('{ST_JR, 1'($urandom)});
            default: for (int i = 0; i < 10; i++) q.push_back('{ST_TRAP, 1'($urandom)});
        endcase
        for (int i = 0; i < q.size(); i++) begin
            ctrl_t e;
            @(negedge clk);
            mem_ready = q[i].rdy;
            zero = 1'($urandom);
            #1;
            e = exp_ctrl(q[i].st, op, fn, q[i].rdy);
            checks += 3;
            if (state !== q[i].st) begin
                errors++;
                $display("[TB] FAIL state op=%h fn=%h step=%0d got=%0d exp=%0d",
                         op, fn, i, state, q[i].st);
            end
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL ctrl op=%h fn=%h step=%0d got=%h exp=%h",
                         op, fn, i, obs, e);
            end
            if (instr_count !== model_count) begin
                errors++;
                $display("[TB] FAIL count op=%h step=%0d got=%0d exp=%0d",
                         op, i, instr_count, model_count);
            end
            if (i == abort_at) begin
                apply_reset(1);
                return;
            end
        end
        if (cls == C_ILL) apply_reset(1);
        else model_count = model_count + 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        apply_reset(2);
    endtask

    task automatic test_rtype();
        $display("[TB] test_rtype");
        run_instr(6'h00, 6'h22, 0, 0, -1);
        run_instr(6'h00, 6'h2A, 1, 0, -1);
        run_instr(6'h00, 6'h08, 0, 0, -1);
    endtask

    task automatic test_mem_wait();
        $display("[TB] test_mem_wait");
        run_instr(6'h23, 6'h03, 0, 2, -1);
        run_instr(6'h2B, 6'h10, 2, 3, -1);
    endtask

    task automatic test_branch_jump();
        $display("[TB] test_branch_jump");
        run_instr(6'h04, 6'h01, 0, 0, -1);
        run_instr(6'h04, 6'h01, 0, 0, -1);
        run_instr(6'h03, 6'h33, 0, 0, -1);
        run_instr(6'h02, 6'h00, 0, 0, -1);
    endtask

    // Back-to-back random legal instructions with random memory stalls.
    // The run retires enough instructions to wrap the counter.
    task automatic test_back_to_back();
        logic [5:0] rfn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [5:0] ops [9] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h03, 6'h00, 6'h08, 6'h0D};
        $display("[TB] test_back_to_back");
        for (int n = 0; n < 40; n++) begin
            int k;
            logic [5:0] fn;
            k = $urandom_range(0, 8);
            fn = 6'($urandom);
            if (k == 2) fn = rfn[$urandom_range(0, 4)];
            if (k == 6) fn = 6'h08;
            run_instr(ops[k], fn, $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
    endtask

    task automatic test_trap();
        $display("[TB] test_trap");
        run_instr(6'h3F, 6'h20, 0, 0, -1);
        run_instr(6'h00, 6'h01, 0, 0, -1);
        run_instr(6'h0D, 6'h25, 0, 0, -1);
    endtask

    task automatic test_reset_abort();
        $display("[TB] test_reset_abort");
        run_instr(6'h00, 6'h20, 0, 0, -1);
        run_instr(6'h0D, 6'h25, 0, 0, 2);
        run_instr(6'h00, 6'h24, 0, 0, -1);
        run_instr(6'h2B, 6'h01, 0, 3, 4);
        run_instr(6'h23, 6'h01, 0, 2, 3);
        run_instr(6'h08, 6'h07, 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem_wait();
        test_branch_jump();
        test_back_to_back();
        test_trap();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM; sequences the shared single-ALU/single-memory datapath through fetch, decode, execute, memory and writeback.
- Consumes opcode/funct from the instruction parser plus the ALU zero flag and a memory ready handshake.
- Drives all datapath mux selects and write enables, flags illegal instructions, and counts retired instructions.

Parameters:
- COUNT_W, 32, width of retired-instruction counter
- TRAP_STICKY, 1, 1 = TRAP held until reset; 0 = TRAP returns to FETCH after one cycle

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  6  instruction[31:26] from parser (valid from DECODE onward)
- funct  in  6  instruction[5:0] from parser
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, imm_zext  out  1 each  datapath controls
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 sext imm<<2
- alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
- illegal  out  1  illegal opcode/funct detected
- state  out  4  current state (debug)
- instr_count  out  COUNT_W  retired instructions

Behaviour:
- States: IDLE0, FETCH1, DECODE2, MEM_ADDR3, MEM_READ4, MEM_WB5, MEM_WRITE6, R_EXEC7, R_WB8, BRANCH9, JUMP10, I_EXEC11, I_WB12, JAL13, JR14, TRAP15.
- Reset: state=IDLE, instr_count=0, illegal=0; every output 0 in IDLE. rst overrides everything incl. mid-instruction and mid-memory-wait; no partial writes after reset edge.
- IDLE -> FETCH unconditionally.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_source=00. ir_write and pc_write = mem_ready (Mealy). Stay while mem_ready=0; -> DECODE when 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target precompute). Dispatch: 0x23/0x2B -> MEM_ADDR; 0x00 with funct 0x20/22/24/25/2A -> R_EXEC, funct 0x08 -> JR; 0x04 -> BRANCH; 0x08/0x0D -> I_EXEC; 0x02 -> JUMP; 0x03 -> JAL; anything else -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add; -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, iord=1; wait on mem_ready, -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; -> FETCH.
- MEM_WRITE: mem_write=1, iord=1; held until mem_ready, then -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (20 add, 22 sub, 24 and, 25 or, 2A slt); -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01; PC loads iff zero=1; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10; addi: add, imm_zext=0; ori: or, imm_zext=1; -> I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00; -> FETCH.
- JUMP: pc_write=1, pc_source=10; -> FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10 (PC already +4); -> FETCH.
- JR: pc_write=1, pc_source=11; -> FETCH.
- TRAP: illegal=1, no write enables. TRAP_STICKY=1: hold until rst; else -> FETCH after one cycle, illegal drops on leaving.
- Retire: instr_count += 1 (wraps at 2^COUNT_W) on the cycle leaving MEM_WB, MEM_WRITE (with mem_ready), R_WB, BRANCH, I_WB, JUMP, JAL, JR. TRAP never retires.
- Latency with mem_ready=1 (FETCH→next FETCH): lw 5; sw, R-type, addi, ori 4; beq, j, jal, jr 3.
- Each extra mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one cycle; outputs held constant while waiting.
- Any unassigned output in a state is 0.

Test Plan:
- rst 2 cycles, release, mem_ready=1, issue sub $2,$8,$3 (op 0, funct 0x22) -> IDLE,FETCH,DECODE,R_EXEC(alu_ctrl=0110),R_WB(reg_write=1, reg_dst=01) -> FETCH; instr_count=1.
- lw $26,3($30) with mem_ready low 2 cycles in MEM_READ -> 7-cycle instruction, mem_read/iord held through wait, MEM_WB has mem_to_reg=01.
- beq with zero=0, then beq with zero=1 -> 3 cycles each, pc_write_cond=1 and pc_source=01 in BRANCH both times, instr_count +2.
- jal 563 -> JAL asserts pc_write, reg_write, reg_dst=10, mem_to_reg=10 in same cycle; 3 cycles total.
- Opcode 0x3F, then op 0 funct 0x01 (after reset) -> TRAP, illegal=1 held 10 cycles, instr_count unchanged; rst clears to IDLE.
- ori $8,$0,0x0fa5 with rst asserted in I_EXEC -> next state IDLE, no reg_write, instr_count=0.
